// File: rtl/div_pkg.sv
// Shared sizing and request-entry layout for the divider issue queue.
package div_pkg;
  localparam int DIV_DEPTH = 4;
  localparam int DIV_TAG_W = 4;

  typedef struct packed {
    logic [31:0]          rn;
    logic [31:0]          rm;
    logic                 op;
    logic [DIV_TAG_W-1:0] tag;
  } div_req_t;
endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO for the divider issue queue: storage, wrapping pointers, occupancy.
// The parent guarantees no push when full and no pop when empty.
module div_req_fifo import div_pkg::*; #(
  parameter int DEPTH = DIV_DEPTH
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_push,
  input  logic     i_pop,
  input  div_req_t i_data,
  output div_req_t o_head,
  output logic     o_empty,
  output logic     o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  div_req_t      r_mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
endmodule

// File: rtl/div_issue_queue.sv
// Issue queue in front of a combinational divider: request FIFO plus one output register.
// Optional macro DIV_ZERO_TRAP_EN forces out_y=0 / out_dz=1 for a zero divisor.
module div_issue_queue import div_pkg::*; #(
  parameter int DEPTH = DIV_DEPTH,
  parameter int TAG_W = DIV_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_rn,
  input  logic [31:0]      in_rm,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      div_rn,
  output logic [31:0]      div_rm,
  output logic             div_op,
  input  logic [31:0]      div_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz
);
  div_req_t w_push_ent;
  div_req_t w_head;
  logic     w_empty;
  logic     w_full;
  logic     w_push;
  logic     w_pop;
  logic     w_dz;
  logic [31:0] w_y;

  logic             r_out_valid;
  logic [31:0]      r_out_y;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_dz;

  assign w_push_ent.rn  = in_rn;
  assign w_push_ent.rm  = in_rm;
  assign w_push_ent.op  = in_op;
  assign w_push_ent.tag = DIV_TAG_W'(in_tag);

  // No full-bypass: a pop in the same cycle does not open a slot.
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_pop    = !w_empty && (!r_out_valid || out_ready);

  div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_ent),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign div_rn = w_empty ? '0   : w_head.rn;
  assign div_rm = w_empty ? '0   : w_head.rm;
  assign div_op = w_empty ? 1'b0 : w_head.op;

`ifdef DIV_ZERO_TRAP_EN
  assign w_dz = (w_head.rm == '0);
  assign w_y  = w_dz ? '0 : div_y;
`else
  assign w_dz = 1'b0;
  assign w_y  = div_y;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_tag   <= '0;
      r_out_dz    <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_y     <= w_y;
      r_out_tag   <= TAG_W'(w_head.tag);
      r_out_dz    <= w_dz;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_tag   = r_out_tag;
  assign out_dz    = r_out_dz;
endmodule
